median_filter_param: RTL and testbench
======================================

MEDIAN_FILTER_PARAM -- requirements
Module: median_filter_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel bit width.
REQ-002 SHALL have parameter IMG_W, default 9, pixels per row; legal range 3..4096.
REQ-003 SHALL have parameter IMG_H, default 9, rows per frame; legal range 3..4096.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port grayscale_i  input  DATA_W  input pixel, raster order.
REQ-007 SHALL have port done_i  input  1  pixel-valid strobe; grayscale_i is consumed in every cycle done_i=1.
REQ-008 SHALL have port mode_i  input  2  filter mode: 00 median, 01 min, 10 max, 11 bypass (center pixel).
REQ-009 SHALL have port median_o  output  DATA_W  filtered pixel.
REQ-010 SHALL have port done_o  output  1  median_o valid strobe.
REQ-011 SHALL have port frame_done_o  output  1  one-cycle pulse coincident with the last done_o of a frame.

Function
REQ-012 SHALL track column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1); both advance only on done_i=1; col wraps to 0 and row increments at IMG_W-1; both wrap to 0 after pixel (IMG_H-1, IMG_W-1), starting the next frame with no idle cycle required.
REQ-013 SHALL hold two line buffers of IMG_W x DATA_W storing the previous two rows; written only on done_i=1.
REQ-014 SHALL form a 3x3 window of rows row-2..row and columns col-2..col when pixel (row,col) is accepted with row>=2 and col>=2; window center is (row-1, col-1).
REQ-015 SHALL produce exactly one output per interior center, (IMG_H-2)*(IMG_W-2) outputs per frame, in raster order; no outputs for border centers (no padding).
REQ-016 SHALL assert done_o exactly 4 clk cycles after the done_i cycle carrying the pixel that completes the window (fixed pipeline latency 4, independent of done_i gaps).
REQ-017 SHALL compute median as the 5th smallest of the 9 window values (unsigned compare); min as smallest; max as largest; bypass as the center value.
REQ-018 SHALL sample mode_i on the done_i cycle accepting pixel (0,0) and hold it for the entire frame; mode_i changes mid-frame have no effect until the next frame.
REQ-019 SHALL accept done_i gaps of any length and any pattern; pipeline valid tags flow every cycle, so gaps never stall or duplicate outputs.
REQ-020 SHALL accept a new pixel every cycle (throughput 1 pixel/clk).
REQ-021 SHALL hold median_o at its last value when done_o=0.
REQ-022 SHALL assert frame_done_o with the output for center (IMG_H-2, IMG_W-2) only.

Reset
REQ-023 SHALL on rst=1 immediately clear median_o to 0, done_o to 0, frame_done_o to 0, col/row to 0, all pipeline valid tags to 0, and latched mode to 00.
REQ-024 SHALL not require clearing line buffer contents; stale data never reaches median_o because outputs need two fresh rows.
REQ-025 SHALL, after rst deasserts mid-frame, discard in-flight results (no done_o for them) and treat the next accepted pixel as (0,0).

Verification
REQ-026 SHALL pass: default params, mode 00, 81 pixels values 0..80 continuous -> 49 outputs equal to center value (first 10, last 70); first done_o 4 cycles after pixel index 20; frame_done_o with value 70.
REQ-027 SHALL pass: same frame, mode 01 / 10 / 11 -> outputs center-10 / center+10 / center respectively.
REQ-028 SHALL pass: all-zero frame with single 255 at (4,4), mode 00 -> all 49 outputs 0; mode 10 -> outputs 255 for the 9 centers (3..5,3..5), 0 elsewhere.
REQ-029 SHALL pass: frame 0..80 with done_i toggling 1-0-1-0 and random gaps -> identical 49 output values, each done_o 4 cycles after its completing pixel.
REQ-030 SHALL pass: rst pulsed after 40 pixels, then full 0..80 frame -> no done_o from aborted frame after reset, then exactly 49 correct outputs.
REQ-031 SHALL pass: two back-to-back frames (mode 00 then 10, mode_i changed at pixel 40 of frame 1) -> frame 1 all median, frame 2 all max, two frame_done_o pulses.

Source files
------------

// File: rtl/median_filter_param.sv
// Streaming 3x3 median/min/max/bypass filter over a raster image.
// Two line buffers feed a 3x3 window; fixed four-stage pipeline to output.
module median_filter_param #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 9,
    parameter int IMG_H  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] grayscale_i,
    input  logic              done_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] median_o,
    output logic              done_o,
    output logic              frame_done_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef logic [DATA_W-1:0] pix_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        return min2(min2(a, b), c);
    endfunction

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        return max2(max2(a, b), c);
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    mode_q;
    logic          win_ok;
    logic          last_px;

    pix_t          lb1 [IMG_W];
    pix_t          lb2 [IMG_W];
    pix_t [2:0]    win [3];

    pix_t [2:0]    lo2, mid2, hi2;
    pix_t          c2, c3;
    pix_t          mxlo3, mdmid3, mnhi3, mn3, mx3;
    pix_t          result;

    logic          v1, v2, v3;
    logic          f1, f2, f3;
    logic [1:0]    m1, m2, m3;

    assign win_ok  = (row >= RW'(2)) && (col >= CW'(2));
    assign last_px = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            mode_q <= 2'b00;
        end else if (done_i) begin
            if (col == '0 && row == '0)
                mode_q <= mode_i;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers and window hold no state that must be cleared:
    // a valid window always needs two freshly written rows.
    always_ff @(posedge clk) begin
        if (done_i) begin
            lb2[col] <= lb1[col];
            lb1[col] <= grayscale_i;
            win[0]   <= {lb2[col], win[0][2:1]};
            win[1]   <= {lb1[col], win[1][2:1]};
            win[2]   <= {grayscale_i, win[2][2:1]};
        end
        for (int i = 0; i < 3; i++) begin
            lo2[i]  <= min3(win[i][0], win[i][1], win[i][2]);
            mid2[i] <= med3(win[i][0], win[i][1], win[i][2]);
            hi2[i]  <= max3(win[i][0], win[i][1], win[i][2]);
        end
        c2     <= win[1][1];
        mxlo3  <= max3(lo2[0], lo2[1], lo2[2]);
        mdmid3 <= med3(mid2[0], mid2[1], mid2[2]);
        mnhi3  <= min3(hi2[0], hi2[1], hi2[2]);
        mn3    <= min3(lo2[0], lo2[1], lo2[2]);
        mx3    <= max3(hi2[0], hi2[1], hi2[2]);
        c3     <= c2;
    end

    always_comb begin
        result = c3;
        unique case (m3)
            2'b00: result = med3(mxlo3, mdmid3, mnhi3);
            2'b01: result = mn3;
            2'b10: result = mx3;
            2'b11: result = c3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            v3           <= 1'b0;
            f1           <= 1'b0;
            f2           <= 1'b0;
            f3           <= 1'b0;
            m1           <= 2'b00;
            m2           <= 2'b00;
            m3           <= 2'b00;
            median_o     <= '0;
            done_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            v1           <= done_i && win_ok;
            f1           <= done_i && last_px;
            m1           <= mode_q;
            v2           <= v1;
            f2           <= f1;
            m2           <= m1;
            v3           <= v2;
            f3           <= f2;
            m3           <= m2;
            done_o       <= v3;
            frame_done_o <= v3 && f3;
            if (v3)
                median_o <= result;
        end
    end

endmodule

// File: tb/tb_median_filter_param.sv
// Randomized and directed bench for median_filter_param.
// Reference model computes each window result from a stored frame image.
module tb_median_filter_param;

    localparam int DW = 8;
    localparam int W  = 9;
    localparam int H  = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] grayscale_i = '0;
    logic          done_i = 1'b0;
    logic [1:0]    mode_i = 2'b00;
    logic [DW-1:0] median_o;
    logic          done_o;
    logic          frame_done_o;

    median_filter_param #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .grayscale_i  (grayscale_i),
        .done_i       (done_i),
        .mode_i       (mode_i),
        .median_o     (median_o),
        .done_o       (done_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
        int fd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   img[H][W];
    int   mr = 0;
    int   mc = 0;
    int   mmode = 0;
    int   last_val = 0;
    int   fd_seen = 0;
    int   fd_exp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%0d expected=%0d cycle=%0d",
                    tag, obs, exp_v, cyc);
    endtask

    task automatic model_px(input int v, input int m);
        int   w[$];
        exp_t e;
        if (mr == 0 && mc == 0) mmode = m;
        img[mr][mc] = v;
        if (mr >= 2 && mc >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w.push_back(img[mr-2+i][mc-2+j]);
            w.sort();
            e.cyc = cyc + 4;
            e.fd  = (mr == H-1 && mc == W-1) ? 1 : 0;
            case (mmode)
                0: e.val = w[4];
                1: e.val = w[0];
                2: e.val = w[8];
                default: e.val = img[mr-1][mc-1];
            endcase
            q.push_back(e);
            if (e.fd == 1) fd_exp++;
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic step(input bit en, input int v, input int m);
        @(posedge clk);
        #1;
        done_i      = en;
        grayscale_i = DW'(v);
        mode_i      = 2'(m);
        if (en) model_px(v, m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0);
    endtask

    task automatic frame_ramp(input int m, input int gap_kind);
        for (int p = 0; p < W*H; p++) begin
            step(1'b1, p, m);
            if (gap_kind == 1) step(1'b0, 0, m);
            if (gap_kind == 2) idle($urandom_range(0, 3));
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_done_o", int'(done_o), 0);
            chk("rst_median_o", int'(median_o), 0);
            chk("rst_frame_done_o", int'(frame_done_o), 0);
            last_val = 0;
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missing_output_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (done_o) begin
                if (q.size() == 0) begin
                    chk("spurious_done_o", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("value", int'(median_o), e.val);
                    chk("frame_done_o", int'(frame_done_o), e.fd);
                end
                last_val = int'(median_o);
            end else begin
                chk("hold_median_o", int'(median_o), last_val);
                chk("frame_done_wo_done", int'(frame_done_o), 0);
            end
            if (frame_done_o) fd_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle(3);
        #1;
        rst = 1'b0;

        frame_ramp(0, 0);
        idle(6);
        frame_ramp(1, 0);
        frame_ramp(2, 0);
        frame_ramp(3, 0);
        idle(6);

        for (int mm = 0; mm < 3; mm += 2)
            for (int p = 0; p < W*H; p++)
                step(1'b1, (p == 4*W + 4) ? 255 : 0, mm);
        idle(6);

        frame_ramp(0, 1);
        frame_ramp(0, 2);
        idle(6);

        for (int p = 0; p < 40; p++) step(1'b1, p, 0);
        @(posedge clk);
        #1;
        done_i = 1'b0;
        rst    = 1'b1;
        q.delete();
        mr = 0;
        mc = 0;
        idle(2);
        #1;
        rst = 1'b0;
        frame_ramp(0, 0);
        idle(6);

        for (int p = 0; p < W*H; p++) step(1'b1, p, (p < 40) ? 0 : 2);
        frame_ramp(2, 0);
        idle(6);

        for (int f = 0; f < 3; f++) begin
            int m;
            m = $urandom_range(0, 3);
            for (int p = 0; p < W*H; p++) begin
                step(1'b1, $urandom_range(0, 255), m);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
            end
        end
        idle(8);

        chk("queue_drained", q.size(), 0);
        chk("frame_done_pulses", fd_seen, fd_exp);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
